// File: rtl/mux_port_arbiter.sv
// Round-robin arbiter sharing one DATA_W-bit resource between two requesters.
// It drives the mux select and the grants, holds each grant until ack, withdrawal or watchdog expiry.
module mux_port_arbiter #(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     Req0,
  input  logic                     Req1,
  input  logic signed [DATA_W-1:0] Din0,
  input  logic signed [DATA_W-1:0] Din1,
  input  logic                     Res_ack,
  output logic                     Sel,
  output logic                     Gnt0,
  output logic                     Gnt1,
  output logic                     Res_start,
  output logic signed [DATA_W-1:0] Dout,
  output logic                     Dout_valid,
  output logic                     Dout_src,
  output logic                     Timeout_err
);

  localparam int WDOG_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WDOG_W-1:0] WDOG_MAX = WDOG_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  state_t              state_q;
  logic [WDOG_W-1:0]   wdog_q;
  logic                last_q;

  logic                     grant_idx;
  logic                     grant_req;
  logic signed [DATA_W-1:0] grant_din;
  logic                     pick_idx;

  // NOTE: every signal written here gets a value on every path, so no latch is inferred.
  always_comb begin
    grant_idx = (state_q == GNT1);
    grant_req = grant_idx ? Req1 : Req0;
    grant_din = grant_idx ? Din1 : Din0;
    // On a tie the requester that was not served last wins.
    pick_idx  = (Req0 && Req1) ? ~last_q : Req1;
  end

  // NOTE: state and outputs are sequential, so they are assigned with <= only.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q     <= IDLE;
      wdog_q      <= '0;
      last_q      <= 1'b1;
      Sel         <= 1'b0;
      Gnt0        <= 1'b0;
      Gnt1        <= 1'b0;
      Res_start   <= 1'b0;
      Dout        <= '0;
      Dout_valid  <= 1'b0;
      Dout_src    <= 1'b0;
      Timeout_err <= 1'b0;
    end else begin
      Res_start   <= 1'b0;
      Dout_valid  <= 1'b0;
      Timeout_err <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (Req0 || Req1) begin
            state_q   <= pick_idx ? GNT1 : GNT0;
            Sel       <= pick_idx;
            Gnt0      <= ~pick_idx;
            Gnt1      <= pick_idx;
            Res_start <= 1'b1;
            wdog_q    <= '0;
          end
        end
        GNT0, GNT1: begin
          if (Res_ack) begin
            Dout       <= grant_din;
            Dout_valid <= 1'b1;
            Dout_src   <= grant_idx;
          end
          if (Res_ack || !grant_req || (wdog_q == WDOG_MAX)) begin
            state_q     <= IDLE;
            Gnt0        <= 1'b0;
            Gnt1        <= 1'b0;
            last_q      <= grant_idx;
            // Reaching here without ack or withdrawal means the watchdog fired.
            Timeout_err <= !Res_ack && grant_req;
          end else begin
            wdog_q <= wdog_q + WDOG_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mux_port_arbiter.sv
// Self-checking bench for mux_port_arbiter: directed scenarios plus a randomized run
// compared cycle by cycle against an owner/age reference model.
module tb_mux_port_arbiter;

  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 16;

  logic                     Clk = 1'b0;
  logic                     Reset = 1'b0;
  logic                     Req0 = 1'b0;
  logic                     Req1 = 1'b0;
  logic                     Res_ack = 1'b0;
  logic signed [DATA_W-1:0] Din0 = '0;
  logic signed [DATA_W-1:0] Din1 = '0;
  logic                     Sel, Gnt0, Gnt1, Res_start, Dout_valid, Dout_src, Timeout_err;
  logic signed [DATA_W-1:0] Dout;

  int n_vec = 0;
  int n_err = 0;

  mux_port_arbiter #(.DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .Clk(Clk), .Reset(Reset), .Req0(Req0), .Req1(Req1), .Din0(Din0), .Din1(Din1),
    .Res_ack(Res_ack), .Sel(Sel), .Gnt0(Gnt0), .Gnt1(Gnt1), .Res_start(Res_start),
    .Dout(Dout), .Dout_valid(Dout_valid), .Dout_src(Dout_src), .Timeout_err(Timeout_err)
  );

  always #5 Clk = ~Clk;

  // Reference model: who owns the resource (-1 = nobody), how many cycles it has held it,
  // who was served last, and the output values the rules demand.
  typedef struct {
    int                       owner;
    int                       age;
    bit                       last;
    bit                       sel, gnt0, gnt1, start, valid, src, terr;
    logic signed [DATA_W-1:0] dout;
  } model_t;

  model_t m;

  function automatic model_t model_next(model_t c);
    model_t n;
    int     cand;
    bit     req_x;
    n = c;
    n.start = 0; n.valid = 0; n.terr = 0;
    if (!Reset) begin
      n.owner = -1; n.age = 0; n.last = 1; n.sel = 0; n.dout = '0; n.src = 0;
    end else if (c.owner < 0) begin
      cand = -1;
      if (Req0 && Req1) cand = c.last ? 0 : 1;
      else if (Req0)    cand = 0;
      else if (Req1)    cand = 1;
      if (cand >= 0) begin
        n.owner = cand; n.age = 0; n.start = 1; n.sel = (cand == 1);
      end
    end else begin
      req_x = (c.owner == 1) ? Req1 : Req0;
      if (Res_ack) begin
        n.dout = (c.owner == 1) ? Din1 : Din0;
        n.valid = 1; n.src = (c.owner == 1); n.last = (c.owner == 1); n.owner = -1;
      end else if (!req_x) begin
        n.last = (c.owner == 1); n.owner = -1;
      end else if (c.age == TIMEOUT - 1) begin
        n.terr = 1; n.last = (c.owner == 1); n.owner = -1;
      end else begin
        n.age = c.age + 1;
      end
    end
    n.gnt0 = (n.owner == 0);
    n.gnt1 = (n.owner == 1);
    return n;
  endfunction

  always @(posedge Clk) m <= model_next(m);

  task automatic tick();
    @(negedge Clk);
  endtask

  task automatic test_reset();
    Reset = 1'b0; Req0 = 1'b1; Req1 = 1'b1; Res_ack = 1'b1;
    repeat (2) tick();
    n_vec++;
    if ({Sel, Gnt0, Gnt1, Res_start, Dout_valid, Dout_src, Timeout_err} !== 7'b0 || Dout !== '0) begin
      n_err++;
      $display("FAIL reset_state: got flags=%b dout=%h, want flags=0000000 dout=0",
               {Sel, Gnt0, Gnt1, Res_start, Dout_valid, Dout_src, Timeout_err}, Dout);
    end
    Req0 = 1'b0; Req1 = 1'b0; Res_ack = 1'b0;
  endtask

  task automatic test_single_grant();
    Reset = 1'b1; Req0 = 1'b1; Din0 = -32'sd5;
    tick();
    n_vec++;
    if ({Gnt0, Gnt1, Sel, Res_start} !== 4'b1001) begin
      n_err++; $display("FAIL single_grant_rise: got g0/g1/sel/start=%b want 1001", {Gnt0, Gnt1, Sel, Res_start});
    end
    tick();
    n_vec++;
    if ({Gnt0, Res_start} !== 2'b10) begin
      n_err++; $display("FAIL single_start_pulse: got g0/start=%b want 10", {Gnt0, Res_start});
    end
    Res_ack = 1'b1; Req0 = 1'b0;
    tick();
    n_vec++;
    if (Dout !== 32'hFFFF_FFFB || {Dout_valid, Dout_src, Gnt0} !== 3'b100) begin
      n_err++; $display("FAIL single_capture: got dout=%h v/src/g0=%b want dout=fffffffb v/src/g0=100",
                        Dout, {Dout_valid, Dout_src, Gnt0});
    end
    Res_ack = 1'b0;
    tick();
    n_vec++;
    if (Dout_valid !== 1'b0) begin
      n_err++; $display("FAIL single_valid_pulse: got valid=%b want 0", Dout_valid);
    end
  endtask

  task automatic test_alternate();
    bit                       exp;
    logic signed [DATA_W-1:0] exp_d;
    Reset = 1'b0; tick(); Reset = 1'b1;
    Din0 = 32'sd100; Din1 = 32'sd200; Req0 = 1'b1; Req1 = 1'b1;
    tick();
    for (int g = 0; g < 4; g++) begin
      exp   = g[0];
      exp_d = exp ? 32'sd200 : 32'sd100;
      n_vec++;
      if ({Gnt0, Gnt1, Sel, Res_start} !== {~exp, exp, exp, 1'b1}) begin
        n_err++; $display("FAIL alt_grant%0d: got g0/g1/sel/start=%b want %b", g,
                          {Gnt0, Gnt1, Sel, Res_start}, {~exp, exp, exp, 1'b1});
      end
      tick(); tick();
      Res_ack = 1'b1;
      tick();
      Res_ack = 1'b0;
      n_vec++;
      if (Dout !== exp_d || {Dout_valid, Dout_src, Gnt0, Gnt1} !== {1'b1, exp, 2'b00}) begin
        n_err++; $display("FAIL alt_capture%0d: got dout=%0d v/src/g0/g1=%b want dout=%0d v/src/g0/g1=%b",
                          g, Dout, {Dout_valid, Dout_src, Gnt0, Gnt1}, exp_d, {1'b1, exp, 2'b00});
      end
      tick();
    end
    Req0 = 1'b0; Req1 = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_timeout();
    Req1 = 1'b1;
    tick();
    n_vec++;
    if (Gnt1 !== 1'b1) begin
      n_err++; $display("FAIL timeout_grant: got g1=%b want 1", Gnt1);
    end
    for (int i = 1; i <= TIMEOUT; i++) begin
      tick();
      if (i < TIMEOUT) begin
        n_vec++;
        if ({Gnt1, Timeout_err} !== 2'b10) begin
          n_err++; $display("FAIL timeout_hold%0d: got g1/to=%b want 10", i, {Gnt1, Timeout_err});
        end
      end else begin
        n_vec++;
        if ({Gnt1, Timeout_err, Dout_valid} !== 3'b010 || Dout !== 32'sd200) begin
          n_err++; $display("FAIL timeout_fire: got g1/to/v=%b dout=%0d want 010 dout=200",
                            {Gnt1, Timeout_err, Dout_valid}, Dout);
        end
      end
    end
    Req1 = 1'b0;
    tick();
    n_vec++;
    if (Timeout_err !== 1'b0) begin
      n_err++; $display("FAIL timeout_pulse: got to=%b want 0", Timeout_err);
    end
  endtask

  task automatic test_ack_at_timeout();
    logic signed [DATA_W-1:0] d;
    d = $signed($urandom);
    Din0 = d; Req0 = 1'b1;
    tick();
    repeat (TIMEOUT - 1) tick();
    Res_ack = 1'b1; Req0 = 1'b0;
    tick();
    n_vec++;
    if ({Dout_valid, Timeout_err, Gnt0} !== 3'b100 || Dout !== d) begin
      n_err++; $display("FAIL ack_vs_timeout: got v/to/g0=%b dout=%h want 100 dout=%h",
                        {Dout_valid, Timeout_err, Gnt0}, Dout, d);
    end
    Res_ack = 1'b0;
    tick();
    n_vec++;
    if (Timeout_err !== 1'b0) begin
      n_err++; $display("FAIL ack_vs_timeout_late: got to=%b want 0", Timeout_err);
    end
  endtask

  task automatic test_reset_mid_grant();
    Req1 = 1'b1;
    tick(); tick();
    n_vec++;
    if (Gnt1 !== 1'b1) begin
      n_err++; $display("FAIL rst_mid_pre: got g1=%b want 1", Gnt1);
    end
    Reset = 1'b0;
    tick();
    n_vec++;
    if ({Sel, Gnt0, Gnt1, Res_start, Dout_valid, Dout_src, Timeout_err} !== 7'b0 || Dout !== '0) begin
      n_err++; $display("FAIL rst_mid_clear: got flags=%b dout=%h want 0000000 dout=0",
                        {Sel, Gnt0, Gnt1, Res_start, Dout_valid, Dout_src, Timeout_err}, Dout);
    end
    Reset = 1'b1; Req0 = 1'b1;
    tick();
    n_vec++;
    if ({Gnt0, Gnt1} !== 2'b10) begin
      n_err++; $display("FAIL rst_mid_first_tie: got g0/g1=%b want 10", {Gnt0, Gnt1});
    end
    Req0 = 1'b0; Req1 = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_withdraw();
    Din0 = 32'sd77; Req0 = 1'b1;
    tick(); tick();
    Req0 = 1'b0;
    tick();
    n_vec++;
    if ({Gnt0, Dout_valid, Timeout_err} !== 3'b000) begin
      n_err++; $display("FAIL withdraw: got g0/v/to=%b want 000", {Gnt0, Dout_valid, Timeout_err});
    end
    Res_ack = 1'b1; Din0 = 32'sd99;
    tick();
    Res_ack = 1'b0;
    n_vec++;
    if ({Gnt0, Gnt1, Dout_valid} !== 3'b000 || Dout !== '0) begin
      n_err++; $display("FAIL idle_ack_ignored: got g0/g1/v=%b dout=%0d want 000 dout=0",
                        {Gnt0, Gnt1, Dout_valid}, Dout);
    end
  endtask

  task automatic test_random();
    int ack_pct;
    ack_pct = 20;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc % 250 == 0) ack_pct = (ack_pct == 20) ? 3 : 20;
      Reset   = ($urandom_range(0, 299) != 0);
      Req0    = Req0 ? ($urandom_range(0, 99) >= 6) : ($urandom_range(0, 99) < 30);
      Req1    = Req1 ? ($urandom_range(0, 99) >= 6) : ($urandom_range(0, 99) < 30);
      Res_ack = ($urandom_range(0, 99) < ack_pct);
      Din0    = $signed($urandom);
      Din1    = $signed($urandom);
      tick();
      n_vec++;
      if ({Sel, Gnt0, Gnt1, Res_start, Dout_valid, Dout_src, Timeout_err} !==
          {m.sel, m.gnt0, m.gnt1, m.start, m.valid, m.src, m.terr} || Dout !== m.dout
          || (Gnt0 && Gnt1)) begin
        n_err++;
        $display("FAIL random cyc %0d: got sel/g0/g1/st/v/src/to=%b dout=%h want %b dout=%h", cyc,
                 {Sel, Gnt0, Gnt1, Res_start, Dout_valid, Dout_src, Timeout_err}, Dout,
                 {m.sel, m.gnt0, m.gnt1, m.start, m.valid, m.src, m.terr}, m.dout);
      end
    end
    Req0 = 1'b0; Req1 = 1'b0; Res_ack = 1'b0; Reset = 1'b1;
  endtask

  initial begin
    test_reset();
    test_single_grant();
    test_alternate();
    test_timeout();
    test_ack_at_timeout();
    test_reset_mid_grant();
    test_withdraw();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL sim_time_limit: run did not finish, limit 2000000 time units");
    $fatal(1);
  end

endmodule
